fifo_ram_ctrl: RTL and testbench
================================

Name: fifo_ram_ctrl

Overview:
- Pointer/flag controller for the team's synchronous FIFO.
- Drives the write port (port 0) and the read port (port 1) of the DUAL_PORT_RAM storage. Presents valid/ready push and pop interfaces to the user.
- RAM read data has 1-cycle latency and holds while the read enable is low, so the RAM output register is the FIFO head stage. The result is first-word-fall-through behaviour at 1 word/cycle.

Parameters:
- DATA_WIDTH, 8, word width; must match the RAM data width.
- ADDR_WIDTH, 8, RAM address width; RAM_DEPTH = 2**ADDR_WIDTH. Total capacity is RAM_DEPTH+1 (RAM plus head stage).

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- wr_valid  in  1  push request
- wr_ready  out  1  push accepted when wr_valid&&wr_ready
- wr_data  in  DATA_WIDTH  push data
- rd_valid  out  1  head word available on rd_data
- rd_ready  in  1  pop when rd_valid&&rd_ready
- rd_data  out  DATA_WIDTH  head word; equals ram_rdata
- count  out  ADDR_WIDTH+1  words held (RAM plus head), 0..RAM_DEPTH+1
- empty  out  1  count==0
- full  out  1  count==RAM_DEPTH+1
- ovf  out  1  sticky: push attempted while !wr_ready
- udf  out  1  sticky: rd_ready while !rd_valid
- clr_err  in  1  synchronous clear of ovf/udf
- ram_addr_0  out  ADDR_WIDTH  write address (wr_ptr)
- ram_ce_0  out  1  write enable strobe
- ram_we_0  out  1  tied 1
- ram_wdata_0  out  DATA_WIDTH  equals wr_data
- ram_addr_1  out  ADDR_WIDTH  read address (rd_ptr)
- ram_ce_1  out  1  read strobe
- ram_we_1  out  1  tied 0
- ram_rdata  in  DATA_WIDTH  RAM port-1 data
- ram_full  out  1  RAM-level full (ram_cnt==RAM_DEPTH); drives RAM full input

Behaviour:
- Reset (async, rst_n low):
  - wr_ptr, rd_ptr and ram_cnt are 0; head_valid is 0.
  - count is 0; ovf and udf are 0; empty is 1; full, wr_ready and rd_valid are 0 until rst_n deasserts.
- State: ram_cnt (0..RAM_DEPTH, ADDR_WIDTH+1 bits); head_valid (1 bit FSM).
- Push:
  - wr_ready = rst_n_synced && (ram_cnt < RAM_DEPTH), using registered ram_cnt only.
  - On push: ram_ce_0=1 and wr_ptr increments mod RAM_DEPTH (natural wrap).
  - Pushes and pops are never blocked by each other combinationally.
- Fetch:
  - fetch = (ram_cnt != 0) && (!head_valid || rd_ready).
  - fetch drives ram_ce_1=1 with ram_addr_1=rd_ptr; rd_ptr increments mod RAM_DEPTH.
- Head FSM:
  - HEAD_EMPTY to HEAD_VALID on fetch.
  - HEAD_VALID stays on pop&&fetch; goes to HEAD_EMPTY on pop&&!fetch; holds otherwise.
  - rd_valid = head_valid. The word appears exactly 1 cycle after fetch (RAM latency).
  - rd_data is held stable while rd_valid && !rd_ready, because the RAM holds data when ce_1=0.
- Counters:
  - ram_cnt += push - fetch.
  - count = ram_cnt + head_valid, combinational from registers.
- Latency:
  - Push into an empty FIFO: write in cycle N, fetch in N+1, rd_valid in N+2.
  - Sustained simultaneous push/pop at steady state: 1 word/cycle, count constant.
- Address hazard: a fetch requires ram_cnt>0 and a write requires ram_cnt<RAM_DEPTH. Same-cycle read and write are therefore never to the same address, and no bypass is needed.
- Full boundary:
  - At ram_cnt==RAM_DEPTH, wr_ready=0 even if a pop occurs that cycle; wr_ready rises the next cycle.
  - A push with wr_valid&&!wr_ready is dropped, sets ovf, and leaves pointers unchanged.
- Empty boundary:
  - rd_ready with !rd_valid sets udf and changes no state.
  - A pop on the last word gives rd_valid=0 next cycle.
- Error flags: clr_err clears ovf/udf. If clr_err and a new error occur in the same cycle, the flag is set (set wins).
- Wrap-around: pointers wrap from RAM_DEPTH-1 to 0 with no extra flag. Order is preserved across the wrap.
- Reset mid-operation: all contents are discarded and flags return to reset values. RAM contents are irrelevant after reset; the head reads 0 since the RAM clears its output.

Test Plan:
- ADDR_WIDTH=2. Push 0x11,0x22,0x33 with rd_ready=0 -> rd_valid at cycle 2 after the first push, rd_data=0x11 held; count=3.
- Fill with 0xA0..0xA4, rd_ready=0 -> after 5 pushes full=1, count=5, wr_ready=0. A 6th push of 0xFF sets ovf=1 and is not stored. Pop all -> 0xA0..0xA4 in order.
- Continuous push 0..15 with rd_ready=1 -> output 0..15 in order with no gaps after the 2-cycle fill; pointers wrap 4 times; count stays ≤2.
- Full FIFO (count=5), simultaneous pop and push of 0x55 -> push refused that cycle; wr_ready=1 next cycle; count=4 after.
- rd_ready=1 on an empty FIFO -> udf=1 with no state change. Assert clr_err -> udf=0 next cycle.
- Load 3 words, pull rst_n low mid-stream -> immediately count=0, empty=1, rd_valid=0, wr_ready=0. After release, a push of 0x77 appears as the first word.

Source files
------------

// File: rtl/fifo_ram_ctrl.sv
// fifo_ram_ctrl: pointer/flag controller for a synchronous FIFO built on a
// dual-port RAM. Port 0 is the write port and port 1 is the read port. The
// RAM output register acts as the head stage, which gives first-word-fall-
// through behaviour at one word per cycle.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   wr_valid/wr_ready       push handshake, data on wr_data
//   rd_valid/rd_ready       pop handshake, head word on rd_data (= ram_rdata)
//   count, empty, full      occupancy (RAM words plus head stage)
//   ovf, udf, clr_err       sticky push-overflow and pop-underflow flags, sync clear
//   ram_*_0                 RAM write port (addr, ce, we=1, wdata)
//   ram_*_1, ram_rdata      RAM read port (addr, ce, we=0, rdata)
//   ram_full                RAM-level full (every RAM word occupied)
module fifo_ram_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  ovf,
    output logic                  udf,
    input  logic                  clr_err,
    output logic [ADDR_WIDTH-1:0] ram_addr_0,
    output logic                  ram_ce_0,
    output logic                  ram_we_0,
    output logic [DATA_WIDTH-1:0] ram_wdata_0,
    output logic [ADDR_WIDTH-1:0] ram_addr_1,
    output logic                  ram_ce_1,
    output logic                  ram_we_1,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  ram_full
);

    localparam int unsigned RAM_DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W     = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] RAM_DEPTH_C = CNT_W'(RAM_DEPTH);
    localparam logic [CNT_W-1:0] FULL_C      = CNT_W'(RAM_DEPTH + 1);

    typedef enum logic {
        HEAD_EMPTY = 1'b0,
        HEAD_VALID = 1'b1
    } head_state_e;

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      ram_cnt_q, ram_cnt_d;
    head_state_e           head_q, head_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic [1:0]            rst_sync_q, rst_sync_d;

    logic head_valid;
    logic push;
    logic pop;
    logic fetch;

    // Release pushes only after reset deassertion has been retimed to clk.
    assign rst_sync_d = {rst_sync_q[0], 1'b1};

    // Handshake decode; ready depends only on registered state.
    assign head_valid = (head_q == HEAD_VALID);
    assign wr_ready   = rst_sync_q[1] && (ram_cnt_q < RAM_DEPTH_C);
    assign push       = wr_valid && wr_ready;
    assign pop        = head_valid && rd_ready;
    // Refill the head whenever it is empty or being consumed this cycle.
    assign fetch      = (ram_cnt_q != '0) && (!head_valid || rd_ready);

    // Next-state logic for pointers, counters, head FSM and error flags.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        ram_cnt_d = ram_cnt_q;
        head_d    = head_q;
        ovf_d     = ovf_q;
        udf_d     = udf_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (fetch) begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
        end
        ram_cnt_d = ram_cnt_q + CNT_W'(push) - CNT_W'(fetch);

        case (head_q)
            HEAD_EMPTY: if (fetch) head_d = HEAD_VALID;
            HEAD_VALID: if (pop && !fetch) head_d = HEAD_EMPTY;
            default:    head_d = HEAD_EMPTY;
        endcase

        // A new error in the same cycle as clr_err keeps the flag set.
        if (clr_err) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (wr_valid && !wr_ready) begin
            ovf_d = 1'b1;
        end
        if (rd_ready && !head_valid) begin
            udf_d = 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ram_cnt_q  <= '0;
            head_q     <= HEAD_EMPTY;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            rst_sync_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ram_cnt_q  <= ram_cnt_d;
            head_q     <= head_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
            rst_sync_q <= rst_sync_d;
        end
    end

    // User-side status.
    assign rd_valid = head_valid;
    assign rd_data  = ram_rdata;
    assign count    = ram_cnt_q + CNT_W'(head_valid);
    assign empty    = (count == '0);
    assign full     = (count == FULL_C);
    assign ovf      = ovf_q;
    assign udf      = udf_q;

    // RAM ports; fetch needs ram_cnt>0 and write needs ram_cnt<depth, so the
    // two ports never address the same word in one cycle.
    assign ram_addr_0  = wr_ptr_q;
    assign ram_ce_0    = push;
    assign ram_we_0    = 1'b1;
    assign ram_wdata_0 = wr_data;
    assign ram_addr_1  = rd_ptr_q;
    assign ram_ce_1    = fetch;
    assign ram_we_1    = 1'b0;
    assign ram_full    = (ram_cnt_q == RAM_DEPTH_C);

endmodule

// File: tb/tb_fifo_ram_ctrl.sv
// Testbench for fifo_ram_ctrl with a 4-word RAM (capacity 5).
module tb_fifo_ram_ctrl;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 2;
    localparam int          DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [DW-1:0] wr_data = '0;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic [DW-1:0] rd_data;
    logic [AW:0]   count;
    logic          empty, full, ovf, udf;
    logic          clr_err = 1'b0;
    logic [AW-1:0] ram_addr_0, ram_addr_1;
    logic          ram_ce_0, ram_we_0, ram_ce_1, ram_we_1, ram_full;
    logic [DW-1:0] ram_wdata_0, ram_rdata;

    always #5 clk = ~clk;

    fifo_ram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .count(count), .empty(empty), .full(full),
        .ovf(ovf), .udf(udf), .clr_err(clr_err),
        .ram_addr_0(ram_addr_0), .ram_ce_0(ram_ce_0), .ram_we_0(ram_we_0),
        .ram_wdata_0(ram_wdata_0),
        .ram_addr_1(ram_addr_1), .ram_ce_1(ram_ce_1), .ram_we_1(ram_we_1),
        .ram_rdata(ram_rdata), .ram_full(ram_full)
    );

    // Dual-port RAM: 1-cycle read latency, output holds when ce_1 is low,
    // output register cleared by reset.
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] ram_q;
    always @(posedge clk) begin
        if (ram_ce_0 && ram_we_0) mem[ram_addr_0] <= ram_wdata_0;
    end
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ram_q <= '0;
        else if (ram_ce_1 && !ram_we_1) ram_q <= mem[ram_addr_1];
    end
    assign ram_rdata = ram_q;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the words held, each stamped with its push cycle.
    // A word shows at the head two cycles after its push, and no earlier
    // than one cycle after the previous word left.
    typedef struct {
        logic [DW-1:0] d;
        int            t;
    } ent_t;

    ent_t          mq[$];
    int            cyc;
    int            last_pop;
    bit            m_ovf, m_udf;
    logic [DW-1:0] got[$];
    int            got_t[$];

    function automatic int maxi(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic bit m_rd_valid();
        if (mq.size() == 0) return 1'b0;
        return cyc >= maxi(mq[0].t + 2, last_pop + 1);
    endfunction

    function automatic int m_ram_cnt();
        return mq.size() - (m_rd_valid() ? 1 : 0);
    endfunction

    function automatic bit m_wr_ready();
        return m_ram_cnt() < DEPTH;
    endfunction

    // One clock cycle: drive, compare against model at negedge, advance model.
    task automatic step(input logic wv, input logic [DW-1:0] wd, input logic rr, input logic ce);
        bit ev, er;
        wr_valid = wv; wr_data = wd; rd_ready = rr; clr_err = ce;
        @(negedge clk);
        ev = m_rd_valid();
        er = m_wr_ready();
        chk("count",    32'(count),    32'(mq.size()));
        chk("empty",    32'(empty),    32'(mq.size() == 0));
        chk("full",     32'(full),     32'(mq.size() == DEPTH + 1));
        chk("wr_ready", 32'(wr_ready), 32'(er));
        chk("rd_valid", 32'(rd_valid), 32'(ev));
        if (ev) chk("rd_data", 32'(rd_data), 32'(mq[0].d));
        chk("ovf",      32'(ovf),      32'(m_ovf));
        chk("udf",      32'(udf),      32'(m_udf));
        chk("ram_full", 32'(ram_full), 32'(m_ram_cnt() == DEPTH));
        if (wv && !er) m_ovf = 1'b1;
        else if (ce)   m_ovf = 1'b0;
        if (rr && !ev) m_udf = 1'b1;
        else if (ce)   m_udf = 1'b0;
        if (rr && ev) begin
            got.push_back(mq[0].d);
            got_t.push_back(cyc);
            mq.delete(0);
            last_pop = cyc;
        end
        if (wv && er) mq.push_back('{d: wd, t: cyc});
        @(posedge clk);
        #1;
        cyc++;
        wr_valid = 1'b0; rd_ready = 1'b0; clr_err = 1'b0;
    endtask

    // Asynchronous reset with immediate checks of the reset values.
    task automatic do_reset();
        wr_valid = 1'b0; rd_ready = 1'b0; clr_err = 1'b0; wr_data = '0;
        rst_n = 1'b0;
        #1;
        chk("rst count",    32'(count),    32'd0);
        chk("rst empty",    32'(empty),    32'd1);
        chk("rst full",     32'(full),     32'd0);
        chk("rst wr_ready", 32'(wr_ready), 32'd0);
        chk("rst rd_valid", 32'(rd_valid), 32'd0);
        chk("rst ovf",      32'(ovf),      32'd0);
        chk("rst udf",      32'(udf),      32'd0);
        chk("rst rd_data",  32'(rd_data),  32'd0);
        chk("rst ram_full", 32'(ram_full), 32'd0);
        chk("rst we ports", 32'({ram_we_0, ram_we_1}), 32'b10);
        mq.delete(); got.delete(); got_t.delete();
        m_ovf = 1'b0; m_udf = 1'b0; last_pop = -100; cyc = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic          wv;
        logic [DW-1:0] wd;
        logic          rr;
        logic          ce;
        logic          e_wr_ready;
        logic          e_rd_valid;
        logic [DW-1:0] e_data;
        logic [AW:0]   e_count;
        logic          e_ovf;
        logic          e_udf;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Push 11,22,33 held, then drain and underflow/clear.
        tbl[0] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd1, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 3'd2, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 3'd3, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 3'd3, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 3'd2, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h33, 3'd1, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1};
        tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};

        #2;
        do_reset();

        for (int i = 0; i < 10; i++) begin
            wr_valid = tbl[i].wv; wr_data = tbl[i].wd;
            rd_ready = tbl[i].rr; clr_err = tbl[i].ce;
            @(negedge clk);
            chk("tbl wr_ready", 32'(wr_ready), 32'(tbl[i].e_wr_ready));
            chk("tbl rd_valid", 32'(rd_valid), 32'(tbl[i].e_rd_valid));
            if (tbl[i].e_rd_valid) chk("tbl rd_data", 32'(rd_data), 32'(tbl[i].e_data));
            chk("tbl count",    32'(count),    32'(tbl[i].e_count));
            chk("tbl ovf",      32'(ovf),      32'(tbl[i].e_ovf));
            chk("tbl udf",      32'(udf),      32'(tbl[i].e_udf));
            @(posedge clk);
            #1;
        end
        wr_valid = 1'b0; rd_ready = 1'b0; clr_err = 1'b0;

        // Fill to capacity, overflow push, drain in order.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
        chk("fill full",     32'(full),     32'd1);
        chk("fill count",    32'(count),    32'd5);
        chk("fill wr_ready", 32'(wr_ready), 32'd0);
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        chk("fill ovf", 32'(ovf), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("fill pop data", 32'(rd_data), 32'(8'hA0 + 8'(i)));
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("fill drained", 32'(empty), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Streaming 0..15 with rd_ready held high; pointers wrap.
        got.delete(); got_t.delete();
        for (int i = 0; i < 20; i++) begin
            step((i < 16), 8'(i), 1'b1, 1'b0);
            chk("stream count<=2", 32'(count <= 3'd2), 32'd1);
        end
        chk("stream n", 32'(got.size()), 32'd16);
        for (int i = 0; i < 16 && i < got.size(); i++) chk("stream data", 32'(got[i]), 32'(i));
        if (got_t.size() == 16) chk("stream gapless", 32'(got_t[15] - got_t[0]), 32'd15);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Full with simultaneous pop and push: push refused that cycle.
        for (int i = 0; i < 5; i++) step(1'b1, 8'hB0 + 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b1, 1'b0);
        chk("fullpop wr_ready", 32'(wr_ready), 32'd1);
        chk("fullpop count",    32'(count),    32'd4);
        chk("fullpop ovf",      32'(ovf),      32'd1);
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, m_rd_valid(), 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Reset in the middle of a stream.
        for (int i = 0; i < 3; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        do_reset();
        step(1'b1, 8'h77, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("post-rst rd_valid", 32'(rd_valid), 32'd1);
        chk("post-rst rd_data",  32'(rd_data),  32'h77);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Randomized traffic: fill-biased then drain-biased.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 60), 8'($urandom),
                 ($urandom_range(0, 99) < ((i < 200) ? 30 : 75)),
                 ($urandom_range(0, 99) < 4));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
